// File: rtl/picorv32_soc_pkg.sv
// Shared constants and state types for the picorv32 memory/console slice.
package picorv32_soc_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h1000_0000;

  // Bit positions inside the console status word.
  localparam int STAT_FULL = 0;
  localparam int STAT_IDLE = 1;

  typedef enum logic {
    REQ_IDLE,
    REQ_RESP
  } reqState_e;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uartState_e;

endpackage

// File: rtl/picorv32_mem_console_if.sv
// picorv32 native memory bus bundle; the core side is the master.
interface picorv32_mem_console_if;

  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/console_uart_tx.sv
// 8N1 serialiser fed from the console FIFO through a valid/pop handshake.
// A byte is popped when the line is idle, or in the last stop-bit cycle so
// that consecutive frames follow each other with no idle gap.
module console_uart_tx
  import picorv32_soc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       pop_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int BW = $clog2(CLKS_PER_BIT);

  uartState_e    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bitEnd;

  assign bitEnd = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign pop_o  = valid_i && ((state_q == UART_IDLE) || ((state_q == UART_STOP) && bitEnd));
  assign tx_o   = tx_q;
  assign busy_o = (state_q != UART_IDLE);

  // Frame sequencing: start bit, eight data bits LSB first, stop bit.
  always_comb begin
    state_d  = state_q;
    baud_d   = bitEnd ? '0 : baud_q + 1'b1;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    case (state_q)
      UART_IDLE: baud_d = '0;
      UART_START: begin
        if (bitEnd) begin
          state_d  = UART_DATA;
          tx_d     = shift_q[0];
          bitCnt_d = '0;
        end
      end
      UART_DATA: begin
        if (bitEnd) begin
          if (bitCnt_q == 3'd7) begin
            state_d = UART_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d  = shift_q >> 1;
            tx_d     = shift_q[1];
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end
      end
      UART_STOP: begin
        if (bitEnd) begin
          state_d = UART_IDLE;
        end
      end
      default: state_d = UART_IDLE;
    endcase
    if (pop_o) begin
      state_d = UART_START;
      shift_d = data_i;
      tx_d    = 1'b0;
      baud_d  = '0;
    end
  end

  // UART state registers; the line returns high right after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= UART_IDLE;
      baud_q   <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/picorv32_mem_console.sv
// Memory-side stage for picorv32: word RAM with a registered one-cycle
// response plus a memory-mapped console that queues bytes for the UART.
// Console writes stall while the FIFO is full, giving the core backpressure.
module picorv32_mem_console
  import picorv32_soc_pkg::*;
#(
  parameter int          MEM_WORDS    = 65536,
  parameter string       INIT_FILE    = "",
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEFAULT,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  picorv32_mem_console_if.slave  bus,
  output logic                   uart_tx,
  output logic                   bad_access
);

  localparam int AW  = $clog2(MEM_WORDS);
  localparam int FAW = $clog2(FIFO_DEPTH);

  logic [31:0]    ram [MEM_WORDS];
  logic [7:0]     fifoMem [FIFO_DEPTH];

  logic [29:0]    wordIdx;
  logic [AW-1:0]  ramIdx;
  logic           isConsole, isRam, isWrite;
  logic           fifoFull, fifoEmpty, accept, push, pop, uartBusy;
  logic           unusedBits;

  reqState_e      state_q, state_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           ramResp_q, ramResp_d;
  logic           bad_q, bad_d;
  logic [31:0]    ramRd_q;
  logic [FAW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [FAW:0]   count_q, count_d;

  assign wordIdx    = bus.mem_addr[31:2];
  assign ramIdx     = wordIdx[AW-1:0];
  assign isConsole  = (wordIdx == CONSOLE_ADDR[31:2]);
  assign isRam      = !isConsole && ({2'b00, wordIdx} < 32'(MEM_WORDS));
  assign isWrite    = (bus.mem_wstrb != 4'b0000);
  assign fifoFull   = (count_q == (FAW + 1)'(FIFO_DEPTH));
  assign fifoEmpty  = (count_q == '0);
  assign accept     = resetn && (state_q == REQ_IDLE) && bus.mem_valid
                      && !(isConsole && isWrite && fifoFull);
  assign push       = accept && isConsole && isWrite;
  assign unusedBits = &{1'b0, bus.mem_instr, bus.mem_addr[1:0]};

  assign bus.mem_ready = (state_q == REQ_RESP);
  assign bus.mem_rdata = ramResp_q ? ramRd_q : rdata_q;
  assign bad_access    = bad_q;

  // Request FSM: accept in IDLE, pulse ready for one cycle in RESP.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    ramResp_d = ramResp_q;
    bad_d     = bad_q;
    case (state_q)
      REQ_IDLE: begin
        if (accept) begin
          state_d   = REQ_RESP;
          ramResp_d = isRam && !isWrite;
          rdata_d   = '0;
          if (isConsole && !isWrite) begin
            rdata_d[STAT_IDLE] = fifoEmpty && !uartBusy;
            rdata_d[STAT_FULL] = fifoFull;
          end
          if (!isConsole && !isRam) begin
            bad_d = 1'b1;
          end
        end
      end
      REQ_RESP: state_d = REQ_IDLE;
      default:  state_d = REQ_IDLE;
    endcase
  end

  // Request registers; a request in flight at reset is dropped silently.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= REQ_IDLE;
      rdata_q   <= '0;
      ramResp_q <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      ramResp_q <= ramResp_d;
      bad_q     <= bad_d;
    end
  end

  // RAM port: byte-lane writes and registered read, both on the accept edge.
  always_ff @(posedge clk) begin
    if (accept && isRam) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_wstrb[b]) begin
          ram[ramIdx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end
      ramRd_q <= ram[ramIdx];
    end
  end

  // Console FIFO pointers and occupancy.
  always_comb begin
    wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO bookkeeping registers; queued bytes are discarded on reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage, written with the low byte of a console write.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr_q] <= bus.mem_wdata[7:0];
    end
  end

  console_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uUart (
    .clk    (clk),
    .resetn (resetn),
    .valid_i(!fifoEmpty),
    .data_i (fifoMem[rdPtr_q]),
    .pop_o  (pop),
    .tx_o   (uart_tx),
    .busy_o (uartBusy)
  );

endmodule
